// File: rtl/i2c_csr_bridge_if.sv
// Pin-side and CSR-side signals of the I2C-to-CSR bridge.
// The bridge itself connects through the slave modport.
interface i2c_csr_bridge_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [4:0] csr_a;
    logic [7:0] csr_dout;
    logic       csr_we;
    logic [7:0] csr_din;

    modport slave (
        input  scl, sda_in, csr_din,
        output sda_oe, csr_a, csr_dout, csr_we
    );

    modport master (
        output scl, sda_in, csr_din,
        input  sda_oe, csr_a, csr_dout, csr_we
    );
endinterface

// File: rtl/i2c_csr_bridge.sv
// I2C slave that turns bus transactions into reads and writes on the shared 5-bit CSR bus.
// The first written byte sets the register pointer; later bytes and reads auto-increment it.
module i2c_csr_bridge #(
    parameter logic [6:0] I2C_ADDR = 7'h4a
) (
    input  logic            clk,
    input  logic            rst,
    i2c_csr_bridge_if.slave bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR     = 4'd1;
    localparam logic [3:0] S_ADDR_ACK = 4'd2;
    localparam logic [3:0] S_REG      = 4'd3;
    localparam logic [3:0] S_REG_ACK  = 4'd4;
    localparam logic [3:0] S_WR       = 4'd5;
    localparam logic [3:0] S_WR_ACK   = 4'd6;
    localparam logic [3:0] S_RD       = 4'd7;
    localparam logic [3:0] S_RD_ACK   = 4'd8;

    logic       scl_p0, scl_p1, scl_p2;
    logic       sda_p0, sda_p1, sda_p2;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic [4:0] ptr;
    logic       rw;
    logic       sda_oe_r;
    logic       csr_we_r;
    logic [7:0] csr_dout_r;

    // Stage p0/p1: two-flop synchronizer; p2: delayed copy for edge detection.
    // Held at the idle-bus level during reset so no phantom start is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= bus.scl;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= bus.sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  =  scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 &  scl_p2;
    assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
    assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;
    assign byte_in   = {shift[6:0], sda_p1};

    // Protocol engine; acts on the event pulses one clk after they form.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            ptr        <= 5'd0;
            rw         <= 1'b0;
            sda_oe_r   <= 1'b0;
            csr_we_r   <= 1'b0;
            csr_dout_r <= 8'd0;
        end else begin
            csr_we_r <= 1'b0;
            if (csr_we_r)
                ptr <= ptr + 5'd1;

            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= 4'd0;
                sda_oe_r <= 1'b0;
            end else if (stop_det) begin
                state    <= S_IDLE;
                sda_oe_r <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (byte_in[7:1] == I2C_ADDR) begin
                                rw    <= byte_in[0];
                                state <= S_ADDR_ACK;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end

                    S_REG, S_WR: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (state == S_REG) begin
                                ptr   <= byte_in[4:0];
                                state <= S_REG_ACK;
                            end else begin
                                csr_we_r   <= 1'b1;
                                csr_dout_r <= byte_in;
                                state      <= S_WR_ACK;
                            end
                        end
                    end

                    // sda_oe doubles as the slot phase: low means the ACK slot has not begun yet.
                    S_ADDR_ACK, S_REG_ACK, S_WR_ACK: if (scl_fall) begin
                        if (!sda_oe_r) begin
                            sda_oe_r <= 1'b1;
                        end else if (state == S_ADDR_ACK && rw) begin
                            shift    <= bus.csr_din;
                            ptr      <= ptr + 5'd1;
                            sda_oe_r <= ~bus.csr_din[7];
                            bit_cnt  <= 4'd1;
                            state    <= S_RD;
                        end else begin
                            sda_oe_r <= 1'b0;
                            state    <= (state == S_ADDR_ACK) ? S_REG : S_WR;
                        end
                    end

                    S_RD: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_r <= 1'b0;
                            state    <= S_RD_ACK;
                        end else begin
                            shift    <= {shift[6:0], 1'b0};
                            sda_oe_r <= ~shift[6];
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end

                    // A NACK ends the read at the rise, so any fall seen here follows an ACK.
                    S_RD_ACK: begin
                        if (scl_rise && sda_p1) begin
                            state <= S_IDLE;
                        end else if (scl_fall) begin
                            shift    <= bus.csr_din;
                            ptr      <= ptr + 5'd1;
                            sda_oe_r <= ~bus.csr_din[7];
                            bit_cnt  <= 4'd1;
                            state    <= S_RD;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe   = sda_oe_r;
    assign bus.csr_a    = ptr;
    assign bus.csr_dout = csr_dout_r;
    assign bus.csr_we   = csr_we_r;
endmodule

// File: doc/i2c_csr_bridge.md
Name: i2c_csr_bridge

Overview:
- I2C slave front end. Decodes bus transactions and drives the shared 5-bit CSR bus consumed by the gpio and other CSR blocks.
- First written byte after the address sets the register pointer. Later bytes write CSRs at the pointer, with auto-increment.
- Reads return the CSR read-mux data (csr_din) at the pointer, with auto-increment.
- Sits between the board I2C pins and all CSR-attached blocks.

Parameters:
- I2C_ADDR, 7'h4a, 7-bit slave address the block ACKs.

Ports:
- clk  input  1  system clock; at least 16x SCL frequency.
- rst  input  1  synchronous, active-high reset.
- scl  input  1  raw SCL pin, asynchronous.
- sda_in  input  1  raw SDA pin, asynchronous.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- csr_a  output  5  CSR address; always equals the register pointer.
- csr_dout  output  8  write data to CSR blocks (their csr_di).
- csr_we  output  1  one-clk write strobe.
- csr_din  input  8  combinational read data from the CSR mux for csr_a.

Behaviour:
- Input conditioning:
  - scl and sda_in pass through a 2-flop synchronizer, then one delay register.
  - Edge detection uses the synchronized and delayed copies.
  - Events (scl_rise, scl_fall, start, stop) are one-clk pulses, 3 clks after the pin change.
- Bus conditions:
  - start = SDA falling while SCL high.
  - stop = SDA rising while SCL high.
  - Data bits are sampled on scl_rise, MSB first.
- State machine: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR, WR_ACK, RD, RD_ACK.
- Global rules:
  - start from any state -> ADDR; bit counter cleared; sda_oe=0. This covers repeated start.
  - stop from any state -> IDLE; sda_oe=0; no CSR write for a partial byte.
- ADDR:
  - After 8 bits, compare bits[7:1] with I2C_ADDR.
  - Mismatch -> IDLE; SDA never driven.
  - Match -> ADDR_ACK; sda_oe=1 on the next scl_fall.
  - R/W=0: next state REG.
  - R/W=1: csr_din is loaded into the shift register at the scl_fall that ends the ACK slot, then pointer+1, then RD.
- REG:
  - After 8 bits, pointer <= byte[4:0]; bits [7:5] are ignored.
  - ACK the byte, then go to WR.
- WR:
  - The cycle after the 8th scl_rise: csr_we=1 for exactly 1 clk, csr_a=pointer, csr_dout=byte.
  - Pointer increments the following clk.
  - ACK the byte (WR_ACK), then return to WR.
- RD:
  - Drive sda_oe = ~shift[7] after each scl_fall; shift left on each scl_fall.
  - After the 8th bit, release SDA and go to RD_ACK.
- RD_ACK:
  - Master ACK (SDA=0 at scl_rise): reload from csr_din at the next scl_fall, pointer+1, back to RD.
  - Master NACK: go to IDLE with SDA released.
- SDA timing:
  - ACK drive begins on the scl_fall after the 8th bit.
  - ACK release happens on the scl_fall that ends the ACK slot, unless the next read bit drives low.
  - SDA never changes while SCL is synchronized high, except after start/stop detection.
- Pointer:
  - 5 bits; wraps 31 -> 0 on both read and write.
  - Persists across transactions; reset to 0.
- Reset values: sda_oe=0, csr_we=0, csr_a=0, csr_dout=0, state=IDLE, pointer=0.
- rst mid-transfer aborts immediately: SDA released, no csr_we.

Test Plan:
- Write: START, 0x94, 0x01, 0xA5, STOP.
  -> ACK on all 3 bytes; single csr_we pulse with csr_a=1, csr_dout=0xA5; final csr_a=2.
- Burst wrap: write pointer 0x1F, then data 0x11, 0x22.
  -> csr_we at a=31 with d=0x11, then a=0 with d=0x22; final pointer 1.
- Read with repeated start: write pointer 0x03, repeated START, 0x95, read 2 bytes (master ACK, then NACK), csr_din model returns 0x40+a.
  -> SDA bits read back 0x43, 0x44; sda_oe=0 after NACK; no csr_we.
- Address mismatch: START, 0x96, 0xFF, STOP.
  -> sda_oe stays 0 throughout; no csr_we; pointer unchanged.
- Abort: STOP after 4 bits of a data byte.
  -> state IDLE; no csr_we. Then assert rst during an ACK slot -> sda_oe=0 the next clk; csr_a=0.
